mips_mc_control: RTL
====================

Name: mips_mc_control

Overview:
- Multicycle control FSM for the MIPS core driven by the MIPS_TB testbench.
- Sits between the instruction register (opcode input) and the datapath's mux selects and write enables. It sequences fetch, decode, execute, memory and writeback for each instruction.
- Also keeps a retired-instruction counter used by the bench to check progress.

Parameters:
- OPW, 6, opcode width (instruction bits 31:26).
- CNTW, 32, width of retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- opcode  input  OPW  IR[31:26], valid from the DECODE state onward.
- zero  input  1  ALU zero flag, used for beq.
- pc_write  output  1  unconditional PC load.
- pc_write_cond  output  1  PC load if zero=1.
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- ir_write  output  1  instruction register load.
- mem_to_reg  output  1  writeback select: 0 = ALUOut, 1 = MDR.
- reg_dst  output  1  destination select: 0 = rt, 1 = rd.
- reg_write  output  1  register file write.
- alu_src_a  output  1  ALU A select: 0 = PC, 1 = A.
- alu_src_b  output  2  ALU B select: 00 = B, 01 = const 4, 10 = signext imm, 11 = signext imm<<2.
- alu_op  output  2  ALU op: 00 = add, 01 = sub, 10 = funct-decoded.
- pc_source  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- retired  output  CNTW  count of completed instructions.
- state  output  4  current state encoding, for debug.

Behaviour:
- Clock and reset
  - One clock. Reset is asynchronous and active-high.
  - While reset=1: state=FETCH, retired=0, and every output is 0, including FETCH's enables. Enables are gated by reset.
  - First FETCH is performed on the first rising edge after reset falls.
  - Reset asserted mid-instruction aborts it immediately. No further write strobes occur and retired is not incremented.
- Outputs are Moore, decoded from state only, apart from the reset gating above. Every output not listed for a state is 0.
- States (4-bit encoding, values in package):
  - FETCH(0): mem_read, ir_write, alu_src_b=01, alu_op=00, pc_write, pc_source=00. Next: DECODE.
  - DECODE(1): alu_src_b=11, alu_op=00. Next by opcode:
    - lw 100011 or sw 101011 -> MEMADR.
    - R-type 000000 -> EXEC.
    - beq 000100 -> BRANCH.
    - j 000010 -> JUMP.
    - addi 001000 -> ADDIEX.
    - any other opcode -> FETCH (ignored, counted as retired).
  - MEMADR(2): alu_src_a=1, alu_src_b=10, alu_op=00. Next: MEMRD if lw, MEMWR if sw.
  - MEMRD(3): mem_read, i_or_d=1. Next: MEMWB.
  - MEMWB(4): reg_write, mem_to_reg=1, reg_dst=0. Next: FETCH.
  - MEMWR(5): mem_write, i_or_d=1. Next: FETCH.
  - EXEC(6): alu_src_a=1, alu_src_b=00, alu_op=10. Next: ALUWB.
  - ALUWB(7): reg_write, reg_dst=1, mem_to_reg=0. Next: FETCH.
  - BRANCH(8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond, pc_source=01. Next: FETCH.
  - JUMP(9): pc_write, pc_source=10. Next: FETCH.
  - ADDIEX(10): alu_src_a=1, alu_src_b=10, alu_op=00. Next: ADDIWB.
  - ADDIWB(11): reg_write, reg_dst=0, mem_to_reg=0. Next: FETCH.
  - Encodings 12-15 are unreachable. If entered, go to FETCH with all outputs 0.
- Latency in cycles, FETCH through last state:
  - lw 5.
  - sw, R-type, addi 4.
  - beq, j 3.
  - illegal opcode 2.
- Retired counter
  - Increments by 1 on the clock edge that moves into FETCH from any non-FETCH state. Not incremented on the edge leaving reset.
  - Wraps modulo 2^CNTW without saturation.
- opcode is sampled only in DECODE and MEMADR. Changes in other states have no effect.
- zero is consumed by the datapath via pc_write_cond; the FSM does not branch on it.

Decomposition:
- Package mips_pkg holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI;
  - state encodings S_FETCH through S_ADDIWB;
  - ALUOp codes and PCSource/ALUSrcB codes.
- One sub-module: mips_ctrl_decode, a combinational state-to-outputs decoder. The top holds the state register, next-state logic, the counter and the reset gating.

Test Plan:
- Reset held 400 ns (2 cycles), then released -> all outputs 0 during reset; state=0 with mem_read=ir_write=pc_write=1 in the first cycle after release; retired=0.
- opcode=100011 (lw) -> states 0,1,2,3,4,0; mem_to_reg=reg_write=1 only in state 4; retired=1 after the return to FETCH.
- opcode=101011 (sw) then 000000 (R-type) -> sw: states 0,1,2,5, mem_write=1 only in 5. R-type: 0,1,6,7, reg_dst=1 and alu_op=10 in 6/7. retired goes 0->1->2.
- opcode=000100 (beq) with zero=1, then opcode=000010 (j) -> beq: pc_write_cond=1 and pc_source=01 in state 8. j: pc_write=1 and pc_source=10 in state 9. Each takes 3 cycles.
- opcode=111111 (illegal) -> states 0,1,0; no reg_write, mem_write or pc_write_cond asserted; retired increments.
- lw in progress, reset pulsed during MEMRD(3) -> outputs 0 immediately (async); state=0 and retired=0; no reg_write pulse after release.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants and types for the multicycle MIPS control unit.
package mips_pkg;

  // Instruction opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // FSM state encodings; 12-15 are unused
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  // ALUOp codes
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALUSrcB codes
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // PCSource codes
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Bundle of all datapath controls
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational Moore decoder: FSM state to datapath control bundle.
module mips_ctrl_decode
  import mips_pkg::*;
(
  input  logic [3:0] state,
  output ctrl_t      ctrl
);

  // Everything defaults to 0; each state raises only its own controls
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMMSH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM with retired-instruction counter.
module mips_mc_control
  import mips_pkg::*;
#(
  parameter int unsigned OPW  = 6,
  parameter int unsigned CNTW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OPW-1:0]  opcode,
  input  logic            zero,
  output logic            pc_write,
  output logic            pc_write_cond,
  output logic            i_or_d,
  output logic            mem_read,
  output logic            mem_write,
  output logic            ir_write,
  output logic            mem_to_reg,
  output logic            reg_dst,
  output logic            reg_write,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_op,
  output logic [1:0]      pc_source,
  output logic [CNTW-1:0] retired,
  output logic [3:0]      state
);

  state_t          state_q, state_d;
  logic [CNTW-1:0] retired_q;
  ctrl_t           ctrl_raw, ctrl_g;

  // zero only reaches the datapath through pc_write_cond
  logic unused_zero;
  assign unused_zero = zero;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic; opcode matters only in DECODE and MEMADR
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LW)      state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FETCH;
      end
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Count each return to FETCH; wraps naturally at 2^CNTW
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_q <= '0;
    end else if ((state_q != S_FETCH) && (state_d == S_FETCH)) begin
      retired_q <= retired_q + CNTW'(1);
    end
  end

  mips_ctrl_decode u_decode (
    .state (state_q),
    .ctrl  (ctrl_raw)
  );

  // Reset forces all controls low, even FETCH's enables
  assign ctrl_g = reset ? '0 : ctrl_raw;

  assign pc_write      = ctrl_g.pc_write;
  assign pc_write_cond = ctrl_g.pc_write_cond;
  assign i_or_d        = ctrl_g.i_or_d;
  assign mem_read      = ctrl_g.mem_read;
  assign mem_write     = ctrl_g.mem_write;
  assign ir_write      = ctrl_g.ir_write;
  assign mem_to_reg    = ctrl_g.mem_to_reg;
  assign reg_dst       = ctrl_g.reg_dst;
  assign reg_write     = ctrl_g.reg_write;
  assign alu_src_a     = ctrl_g.alu_src_a;
  assign alu_src_b     = ctrl_g.alu_src_b;
  assign alu_op        = ctrl_g.alu_op;
  assign pc_source     = ctrl_g.pc_source;
  assign retired       = retired_q;
  assign state         = state_q;

endmodule
